// File: rtl/tl_cpl_gen.sv
// Completion TLP generator: turns one latched completion command into a Cpl/CplD
// header beat plus up to two 128-bit data beats on a valid/ready stream.
module tl_cpl_gen #(
    parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [15:0]  cmd_requester_id_i,
    input  logic [7:0]   cmd_tag_i,
    input  logic [11:0]  cmd_byte_count_i,
    input  logic [6:0]   cmd_lower_addr_i,
    input  logic         cmd_has_data_i,
    input  logic [2:0]   cmd_status_i,
    input  logic [255:0] cmd_data_i,
    output logic [127:0] tx_data_o,
    output logic         tx_sop_o,
    output logic         tx_eop_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    output logic [15:0]  cpl_sent_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [1:0]     last_q, last_d;
    logic [15:0]    rid_q, rid_d;
    logic [7:0]     tag_q, tag_d;
    logic [11:0]    bc_q, bc_d;
    logic [6:0]     la_q, la_d;
    logic           has_data_q, has_data_d;
    logic [2:0]     status_q, status_d;
    logic [255:0]   data_q, data_d;
    logic [3:0]     len_q, len_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           tx_valid_q, tx_valid_d;
    logic           tx_sop_q, tx_sop_d;
    logic           tx_eop_q, tx_eop_d;
    logic [127:0]   tx_data_q, tx_data_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           tx_fire_s;
    logic [3:0]     cmd_len_s;

    function automatic logic [3:0] calc_len_dw(input logic [11:0] bc);
        logic [12:0] sum;
        sum = {1'b0, bc} + 13'd3;
        if (bc == 12'd0) begin
            calc_len_dw = 4'd8;
        end else if (sum[12:2] > 11'd8) begin
            calc_len_dw = 4'd8;
        end else begin
            calc_len_dw = sum[5:2];
        end
    endfunction

    // Index of the final beat: header carries DW0, each data beat carries four more DWs.
    function automatic logic [1:0] calc_last(input logic has_data, input logic [3:0] len);
        if (!has_data) begin
            calc_last = 2'd0;
        end else if (len <= 4'd1) begin
            calc_last = 2'd0;
        end else if (len <= 4'd5) begin
            calc_last = 2'd1;
        end else begin
            calc_last = 2'd2;
        end
    endfunction

    function automatic logic [255:0] mask_payload(input logic [255:0] data, input logic [3:0] len);
        logic [255:0] m;
        m = 256'd0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len) begin
                m[32*i +: 32] = data[32*i +: 32];
            end else begin
                m[32*i +: 32] = 32'd0;
            end
        end
        return m;
    endfunction

    function automatic logic [127:0] build_hdr(
        input logic        has_data,
        input logic [3:0]  len,
        input logic [2:0]  status,
        input logic [11:0] bc,
        input logic [15:0] rid,
        input logic [7:0]  tag,
        input logic [6:0]  la,
        input logic [31:0] dw0
    );
        logic [127:0] h;
        logic [9:0]   len_f;
        h       = 128'd0;
        len_f   = has_data ? {6'd0, len} : 10'd0;
        h[7:5]    = has_data ? 3'b010 : 3'b000;
        h[4:0]    = 5'b01010;
        h[17:16]  = len_f[9:8];
        h[31:24]  = len_f[7:0];
        h[39:32]  = COMPLETER_ID[15:8];
        h[47:40]  = COMPLETER_ID[7:0];
        h[55:53]  = status;
        h[51:48]  = bc[11:8];
        h[63:56]  = bc[7:0];
        h[71:64]  = rid[15:8];
        h[79:72]  = rid[7:0];
        h[87:80]  = tag;
        h[94:88]  = la;
        h[127:96] = has_data ? dw0 : 32'd0;
        return h;
    endfunction

    function automatic logic [127:0] beat_payload(input logic [1:0] beat, input logic [255:0] data);
        logic [127:0] p;
        case (beat)
            2'd1:    p = data[159:32];
            2'd2:    p = {32'd0, data[255:160]};
            default: p = 128'd0;
        endcase
        return p;
    endfunction

    assign tx_fire_s = tx_valid_q & tx_ready_i;
    assign cmd_len_s = calc_len_dw(cmd_byte_count_i);

    // Next-state, command latch and completion counter.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        last_d     = last_q;
        rid_d      = rid_q;
        tag_d      = tag_q;
        bc_d       = bc_q;
        la_d       = la_q;
        has_data_d = has_data_q;
        status_d   = status_q;
        data_d     = data_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    rid_d      = cmd_requester_id_i;
                    tag_d      = cmd_tag_i;
                    bc_d       = cmd_byte_count_i;
                    la_d       = cmd_lower_addr_i;
                    has_data_d = cmd_has_data_i;
                    status_d   = cmd_status_i;
                    len_d      = cmd_len_s;
                    data_d     = mask_payload(cmd_data_i, cmd_len_s);
                    last_d     = calc_last(cmd_has_data_i, cmd_len_s);
                    beat_d     = 2'd0;
                    state_d    = ST_HDR;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_HDR, ST_DATA: begin
                if (tx_fire_s) begin
                    if (beat_q == last_q) begin
                        state_d = ST_IDLE;
                        beat_d  = 2'd0;
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        state_d = ST_DATA;
                        beat_d  = beat_q + 2'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    // Output beat decode from the next state so every output leaves a flop.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        tx_valid_d  = (state_d != ST_IDLE);
        tx_sop_d    = 1'b0;
        tx_eop_d    = 1'b0;
        tx_data_d   = 128'd0;
        if (tx_valid_d) begin
            tx_sop_d = (beat_d == 2'd0);
            tx_eop_d = (beat_d == last_d);
            if (beat_d == 2'd0) begin
                tx_data_d = build_hdr(has_data_d, len_d, status_d, bc_d, rid_d, tag_d, la_d,
                                      data_d[31:0]);
            end else begin
                tx_data_d = beat_payload(beat_d, data_d);
            end
        end else begin
            tx_data_d = 128'd0;
        end
    end

    // Control state and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= 2'd0;
            last_q      <= 2'd0;
            cmd_ready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_data_q   <= 128'd0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            cmd_ready_q <= cmd_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            tx_data_q   <= tx_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // Latched command fields; cleared on reset so an aborted TLP leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid_q      <= 16'd0;
            tag_q      <= 8'd0;
            bc_q       <= 12'd0;
            la_q       <= 7'd0;
            has_data_q <= 1'b0;
            status_q   <= 3'd0;
            data_q     <= 256'd0;
            len_q      <= 4'd0;
        end else begin
            rid_q      <= rid_d;
            tag_q      <= tag_d;
            bc_q       <= bc_d;
            la_q       <= la_d;
            has_data_q <= has_data_d;
            status_q   <= status_d;
            data_q     <= data_d;
            len_q      <= len_d;
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign tx_valid_o     = tx_valid_q;
    assign tx_sop_o       = tx_sop_q;
    assign tx_eop_o       = tx_eop_q;
    assign tx_data_o      = tx_data_q;
    assign cpl_sent_cnt_o = cnt_q;

endmodule

// File: tb/tb_tl_cpl_gen.sv
// Self-checking bench for tl_cpl_gen: a word-list model of the completion TLP
// is compared against beats collected from the DUT under varied tx_ready patterns.
module tb_tl_cpl_gen;

    localparam logic [15:0] CID = 16'h0100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         c_valid;
    logic         cmd_ready_o;
    logic [15:0]  c_rid;
    logic [7:0]   c_tag;
    logic [11:0]  c_bc;
    logic [6:0]   c_la;
    logic         c_hd;
    logic [2:0]   c_st;
    logic [255:0] c_data;
    logic [127:0] tx_data_o;
    logic         tx_sop_o, tx_eop_o, tx_valid_o;
    logic         tx_ready;
    logic [15:0]  cpl_sent_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    logic [127:0] exp_data[$];
    logic [127:0] obs_data[$];
    logic         obs_sop[$];
    logic         obs_eop[$];
    int           obs_n, obs_first, obs_unstable, obs_busy;
    logic         obs_timeout;

    always #5 clk = ~clk;

    tl_cpl_gen #(.COMPLETER_ID(CID)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid_i        (c_valid),
        .cmd_ready_o        (cmd_ready_o),
        .cmd_requester_id_i (c_rid),
        .cmd_tag_i          (c_tag),
        .cmd_byte_count_i   (c_bc),
        .cmd_lower_addr_i   (c_la),
        .cmd_has_data_i     (c_hd),
        .cmd_status_i       (c_st),
        .cmd_data_i         (c_data),
        .tx_data_o          (tx_data_o),
        .tx_sop_o           (tx_sop_o),
        .tx_eop_o           (tx_eop_o),
        .tx_valid_o         (tx_valid_o),
        .tx_ready_i         (tx_ready),
        .cpl_sent_cnt_o     (cpl_sent_cnt_o)
    );

    // Reference: TLP as a list of 32-bit words (3 header DWs + payload), zero-padded to beats.
    task automatic gen_expected();
        int bci, len, plen;
        logic [9:0]  lenf;
        logic [2:0]  fmt;
        logic [31:0] w[$];
        bci  = int'(c_bc);
        len  = (bci == 0) ? 8 : (((bci + 3) / 4 > 8) ? 8 : (bci + 3) / 4);
        plen = c_hd ? len : 0;
        lenf = 10'(plen);
        fmt  = c_hd ? 3'b010 : 3'b000;
        w.push_back({lenf[7:0], 6'b000000, lenf[9:8], 8'h00, fmt, 5'b01010});
        w.push_back({c_bc[7:0], c_st, 1'b0, c_bc[11:8], CID[7:0], CID[15:8]});
        w.push_back({1'b0, c_la, c_tag, c_rid[7:0], c_rid[15:8]});
        for (int i = 0; i < plen; i++) w.push_back(c_data[32*i +: 32]);
        while (w.size() % 4 != 0) w.push_back(32'h0);
        exp_data.delete();
        for (int b = 0; b < w.size() / 4; b++)
            exp_data.push_back({w[4*b+3], w[4*b+2], w[4*b+1], w[4*b]});
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) c_data[32*i +: 32] = $urandom();
    endtask

    // Issue the command held in c_* and collect beats; mode 0 ready=1, 1 toggle, 2 random.
    task automatic run_tlp(input int mode);
        int cyc;
        logic done, prev_stall, r;
        logic [127:0] prev_d;
        logic prev_sop, prev_eop;
        obs_data.delete(); obs_sop.delete(); obs_eop.delete();
        obs_timeout = 1'b0; obs_unstable = 0; obs_busy = 0; obs_first = -1;
        cyc = 0;
        while (!cmd_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
        if (!cmd_ready_o) obs_timeout = 1'b1;
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        cyc = 0; done = 1'b0; prev_stall = 1'b0;
        prev_d = 128'd0; prev_sop = 1'b0; prev_eop = 1'b0;
        while (!done && cyc < 200) begin
            if (tx_valid_o && obs_first < 0) obs_first = cyc;
            if (prev_stall && (tx_data_o !== prev_d || tx_sop_o !== prev_sop ||
                               tx_eop_o !== prev_eop || tx_valid_o !== 1'b1))
                obs_unstable++;
            if (tx_valid_o && cmd_ready_o) obs_busy++;
            case (mode)
                1:       r = (cyc % 2 == 1);
                2:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b1;
            endcase
            tx_ready = r;
            if (tx_valid_o && r) begin
                obs_data.push_back(tx_data_o);
                obs_sop.push_back(tx_sop_o);
                obs_eop.push_back(tx_eop_o);
                if (tx_eop_o) done = 1'b1;
            end
            prev_stall = tx_valid_o && !r;
            prev_d = tx_data_o; prev_sop = tx_sop_o; prev_eop = tx_eop_o;
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b1;
        if (!done) obs_timeout = 1'b1;
        else exp_cnt++;
        obs_n = obs_data.size();
        while (obs_data.size() < 3) begin
            obs_data.push_back('x); obs_sop.push_back(1'bx); obs_eop.push_back(1'bx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; c_valid = 1'b0; tx_ready = 1'b1;
        c_rid = 16'h0; c_tag = 8'h0; c_bc = 12'h0; c_la = 7'h0; c_hd = 1'b0; c_st = 3'h0;
        c_data = 256'h0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tx_valid_o, tx_sop_o, tx_eop_o, cmd_ready_o} !== 4'b0000 || tx_data_o !== 128'd0 ||
            cpl_sent_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v%b s%b e%b rdy%b data %h cnt %h, required all 0",
                     tx_valid_o, tx_sop_o, tx_eop_o, cmd_ready_o, tx_data_o, cpl_sent_cnt_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cmd_ready_o !== 1'b1 || tx_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy %b valid %b, required rdy 1 valid 0",
                     cmd_ready_o, tx_valid_o);
        end
    endtask

    task automatic test_cpl();
        logic [127:0] b0;
        c_hd = 1'b0; c_rid = 16'h1234; c_tag = 8'h5A; c_st = 3'b001;
        c_bc = 12'(($urandom_range(1, 4095))); c_la = 7'($urandom_range(0, 127)); rand_data();
        gen_expected();
        run_tlp(0);
        b0 = obs_data[0];
        n_vec++;
        if (obs_n !== 1 || obs_timeout !== 1'b0 || obs_first !== 0) begin
            n_err++;
            $display("FAIL cpl_shape: got beats %0d timeout %b latency %0d, required 1 0 0",
                     obs_n, obs_timeout, obs_first);
        end
        n_vec++;
        if (b0 !== exp_data[0] || obs_sop[0] !== 1'b1 || obs_eop[0] !== 1'b1) begin
            n_err++;
            $display("FAIL cpl_beat: got %h sop %b eop %b, required %h sop 1 eop 1",
                     b0, obs_sop[0], obs_eop[0], exp_data[0]);
        end
        n_vec++;
        if (b0[7:0] !== 8'h0A || {b0[17:16], b0[31:24]} !== 10'd0 || b0[55:53] !== 3'b001 ||
            b0[71:64] !== 8'h12 || b0[79:72] !== 8'h34 || b0[87:80] !== 8'h5A) begin
            n_err++;
            $display("FAIL cpl_fields: got header %h, required fmt/type 0A len 0 st 1 rid 1234 tag 5A", b0);
        end
        n_vec++;
        if (cpl_sent_cnt_o !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL cpl_count: got %0d required %0d", cpl_sent_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_cpld_short();
        logic [127:0] b0;
        c_hd = 1'b1; c_bc = 12'd4; c_rid = 16'($urandom()); c_tag = 8'($urandom());
        c_la = 7'($urandom()); c_st = 3'b000; rand_data();
        gen_expected();
        run_tlp(0);
        b0 = obs_data[0];
        n_vec++;
        if (obs_n !== 1 || b0 !== exp_data[0] || obs_eop[0] !== 1'b1) begin
            n_err++;
            $display("FAIL cpld_short: got beats %0d data %h eop %b, required 1 %h 1",
                     obs_n, b0, obs_eop[0], exp_data[0]);
        end
        n_vec++;
        if (b0[7:5] !== 3'b010 || {b0[17:16], b0[31:24]} !== 10'd1 || b0[127:96] !== c_data[31:0]) begin
            n_err++;
            $display("FAIL cpld_short_fields: got fmt %b len %0d dw0 %h, required 010 1 %h",
                     b0[7:5], {b0[17:16], b0[31:24]}, b0[127:96], c_data[31:0]);
        end
    endtask

    task automatic test_cpld_full();
        logic [127:0] b2;
        c_hd = 1'b1; c_bc = 12'd32; c_rid = 16'hABCD; c_tag = 8'h11; c_la = 7'h20; c_st = 3'b000;
        for (int i = 0; i < 8; i++) c_data[32*i +: 32] = 32'hDEADBEEF + 32'(i);
        gen_expected();
        run_tlp(0);
        b2 = obs_data[2];
        n_vec++;
        if (obs_n !== 3 || obs_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL cpld_full_beats: got %0d timeout %b, required 3 0", obs_n, obs_timeout);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_sop[i] !== (i == 0) || obs_eop[i] !== (i == 2)) begin
                n_err++;
                $display("FAIL cpld_full_beat%0d: got %h sop %b eop %b, required %h sop %b eop %b",
                         i, obs_data[i], obs_sop[i], obs_eop[i], exp_data[i], i == 0, i == 2);
            end
        end
        n_vec++;
        if (b2[127:96] !== 32'd0 || cpl_sent_cnt_o !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL cpld_full_tail: got top DW %h cnt %0d, required 0 %0d",
                     b2[127:96], cpl_sent_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        c_hd = 1'b1; c_bc = 12'd20; c_rid = 16'($urandom()); c_tag = 8'($urandom());
        c_la = 7'($urandom()); c_st = 3'b010; rand_data();
        gen_expected();
        run_tlp(1);
        n_vec++;
        if (obs_n !== 2 || obs_unstable !== 0 || obs_busy !== 0 || obs_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure: got beats %0d unstable %0d busy_ready %0d timeout %b, required 2 0 0 0",
                     obs_n, obs_unstable, obs_busy, obs_timeout);
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_eop[i] !== (i == 1)) begin
                n_err++;
                $display("FAIL backpressure_beat%0d: got %h eop %b, required %h eop %b",
                         i, obs_data[i], obs_eop[i], exp_data[i], i == 1);
            end
        end
    endtask

    task automatic test_bc_zero();
        logic [127:0] b0;
        c_hd = 1'b1; c_bc = 12'd0; c_rid = 16'($urandom()); c_tag = 8'($urandom());
        c_la = 7'($urandom()); c_st = 3'b100; rand_data();
        gen_expected();
        run_tlp(2);
        b0 = obs_data[0];
        n_vec++;
        if (obs_n !== 3 || {b0[17:16], b0[31:24]} !== 10'd8) begin
            n_err++;
            $display("FAIL bc_zero: got beats %0d len %0d, required 3 8", obs_n, {b0[17:16], b0[31:24]});
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i]) begin
                n_err++;
                $display("FAIL bc_zero_beat%0d: got %h required %h", i, obs_data[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            c_hd = 1'($urandom_range(0, 1)); c_rid = 16'($urandom()); c_tag = 8'($urandom());
            c_la = 7'($urandom()); c_st = 3'($urandom());
            c_bc = ($urandom_range(0, 3) == 0) ? 12'($urandom()) : 12'($urandom_range(0, 36));
            rand_data();
            gen_expected();
            run_tlp(2);
            n_vec++;
            if (obs_n !== exp_data.size() || obs_unstable !== 0 || obs_busy !== 0 ||
                obs_first !== 0 || obs_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL random%0d_shape: got beats %0d unstable %0d busy %0d latency %0d, required %0d 0 0 0",
                         t, obs_n, obs_unstable, obs_busy, obs_first, exp_data.size());
            end
            for (int i = 0; i < exp_data.size(); i++) begin
                n_vec++;
                if (obs_data[i] !== exp_data[i] || obs_sop[i] !== (i == 0) ||
                    obs_eop[i] !== (i == exp_data.size() - 1)) begin
                    n_err++;
                    $display("FAIL random%0d_beat%0d: got %h sop %b eop %b, required %h",
                             t, i, obs_data[i], obs_sop[i], obs_eop[i], exp_data[i]);
                end
            end
        end
        n_vec++;
        if (cpl_sent_cnt_o !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL random_count: got %0d required %0d", cpl_sent_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_a, exp_b, a0, b0;
        int cyc, eop_cyc, sop_cyc, seen;
        c_hd = 1'b1; c_bc = 12'd8; c_rid = 16'h1111; c_tag = 8'hA1; c_la = 7'h01; c_st = 3'b000;
        rand_data();
        gen_expected();
        exp_a = exp_data[0];
        tx_ready = 1'b1;
        cyc = 0;
        while (!cmd_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
        c_valid = 1'b1;
        cyc = 0; eop_cyc = -1; sop_cyc = -1; seen = 0; a0 = 128'd0; b0 = 128'd0; exp_b = 128'd0;
        while (cyc < 100 && sop_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (tx_valid_o && tx_sop_o) begin
                if (seen == 0) begin
                    a0 = tx_data_o;
                    c_rid = 16'h2222; c_tag = 8'hB2; c_bc = 12'd12; c_la = 7'h02;
                    gen_expected();
                    exp_b = exp_data[0];
                    seen = 1;
                end else begin
                    sop_cyc = cyc; b0 = tx_data_o; c_valid = 1'b0;
                end
            end
            if (tx_valid_o && tx_eop_o && seen == 1 && eop_cyc < 0) eop_cyc = cyc;
        end
        c_valid = 1'b0;
        cyc = 0;
        while (tx_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
        exp_cnt += 2;
        n_vec++;
        if (sop_cyc - eop_cyc !== 2 || sop_cyc < 0) begin
            n_err++;
            $display("FAIL b2b_gap: got eop at %0d next sop at %0d, required exactly one idle cycle",
                     eop_cyc, sop_cyc);
        end
        n_vec++;
        if (a0 !== exp_a || b0 !== exp_b) begin
            n_err++;
            $display("FAIL b2b_headers: got %h / %h, required %h / %h", a0, b0, exp_a, exp_b);
        end
        n_vec++;
        if (cpl_sent_cnt_o !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL b2b_count: got %0d required %0d", cpl_sent_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        logic rdy_after;
        c_hd = 1'b1; c_bc = 12'd32; c_rid = 16'h3333; c_tag = 8'hC3; c_la = 7'h03; rand_data();
        tx_ready = 1'b1;
        while (!cmd_ready_o) @(negedge clk);
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_vec++;
        if ({tx_valid_o, tx_sop_o, tx_eop_o, cmd_ready_o} !== 4'b0000 || tx_data_o !== 128'd0 ||
            cpl_sent_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got v%b s%b e%b rdy%b cnt %0d, required all 0",
                     tx_valid_o, tx_sop_o, tx_eop_o, cmd_ready_o, cpl_sent_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        @(negedge clk);
        rdy_after = cmd_ready_o;
        for (int i = 0; i < 6; i++) begin
            if (tx_valid_o || tx_eop_o) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (rdy_after !== 1'b1 || bad !== 0 || cpl_sent_cnt_o !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL reset_mid_release: got rdy %b stale beats %0d cnt %0d, required 1 0 0",
                     rdy_after, bad, cpl_sent_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_cpl();
        test_cpld_short();
        test_cpld_full();
        test_backpressure();
        test_bc_zero();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
